// File: rtl/sound_dsm_dac.sv
// Stereo first-order delta-sigma audio DAC.
// Takes 16-bit signed L/R sample pairs, scales them by a 0..16 anti-pop
// gain, converts to offset binary and drives one 1-bit bitstream per
// channel. The gain ramps up after reset and ramps toward 0 or 16 as mute
// changes, so the analog output fades instead of popping.
module sound_dsm_dac #(
    parameter int DIV    = 1,
    parameter int RAMP_W = 10
) (
    input  logic        m_clock,
    input  logic        p_reset,
    input  logic [15:0] sample_L,
    input  logic [15:0] sample_R,
    input  logic        sample_valid,
    output logic        sample_ack,
    input  logic        mute,
    output logic [4:0]  gain,
    output logic        Sound_Left,
    output logic        Sound_Right
);

    // A 1-bit counter is kept for DIV=1 so the port widths stay legal;
    // it never leaves 0 and tick stays high.
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0]  tick_cnt_reg;
    logic              tick;
    logic [RAMP_W-1:0] ramp_cnt_reg;
    logic              ramp_wrap;
    logic [4:0]        gain_reg;
    logic              ack_reg;
    logic [1:0]        sound_bits;

    assign tick      = (tick_cnt_reg == CNT_LAST);
    assign ramp_wrap = tick && (ramp_cnt_reg == '1);

    // Modulator tick divider: counts 0..DIV-1 and wraps on the tick cycle.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
        end
    end

    // Anti-pop gain ramp: one step toward the mute target per ramp-counter wrap.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            ramp_cnt_reg <= '0;
            gain_reg     <= 5'd0;
        end else if (tick) begin
            ramp_cnt_reg <= ramp_cnt_reg + RAMP_W'(1);
            if (ramp_wrap) begin
                if (!mute && (gain_reg < 5'd16)) begin
                    gain_reg <= gain_reg + 5'd1;
                end else if (mute && (gain_reg != 5'd0)) begin
                    gain_reg <= gain_reg - 5'd1;
                end
            end
        end
    end

    // Every strobe is accepted; the acknowledge follows one cycle later.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            ack_reg <= 1'b0;
        end else begin
            ack_reg <= sample_valid;
        end
    end

    // Per-channel datapath: capture, scale, offset-binary convert, modulate.
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic [15:0]        sample_in;
        logic [15:0]        act_reg;
        logic [15:0]        u_reg;
        logic [15:0]        acc_reg;
        logic               sound_reg;
        logic signed [21:0] act_ext;
        logic signed [21:0] gain_ext;
        logic signed [21:0] prod;
        logic [15:0]        scaled;
        logic [16:0]        sum;
        logic               unused_prod_bits;

        assign sample_in = (gi == 0) ? sample_L : sample_R;

        // Signed sample times unsigned gain; the >>>4 floor shift is a bit
        // select because gain <= 16 keeps the result inside 16 bits.
        assign act_ext          = {{6{act_reg[15]}}, act_reg};
        assign gain_ext         = {17'd0, gain_reg};
        assign prod             = act_ext * gain_ext;
        assign scaled           = prod[19:4];
        assign unused_prod_bits = ^{prod[21:20], prod[3:0]};

        // First-order modulator: the carry out of the phase accumulator is the bit.
        assign sum = {1'b0, acc_reg} + {1'b0, u_reg};

        // Sample hold plus tick-rate scaling and accumulation.
        always_ff @(posedge m_clock or posedge p_reset) begin
            if (p_reset) begin
                act_reg   <= 16'd0;
                u_reg     <= 16'd0;
                acc_reg   <= 16'd0;
                sound_reg <= 1'b0;
            end else begin
                if (sample_valid) begin
                    act_reg <= sample_in;
                end
                if (tick) begin
                    u_reg     <= scaled ^ 16'h8000;
                    acc_reg   <= sum[15:0];
                    sound_reg <= sum[16];
                end
            end
        end

        assign sound_bits[gi] = sound_reg;
    end

    assign sample_ack  = ack_reg;
    assign gain        = gain_reg;
    assign Sound_Left  = sound_bits[0];
    assign Sound_Right = sound_bits[1];

endmodule
